// File: rtl/fix_encoder_if.sv
// fix_encoder_if: byte-stream bundle between the order formatter, the FIX
// encoder and the outbound transport.
//
// Handshake: on both the in_* and out_* streams a byte moves on a rising
// clk edge where valid && ready are both high; the sender holds data and
// sideband stable while valid is high and ready is low, and valid never
// depends on ready.
interface fix_encoder_if;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic       in_sel;
   logic       in_eof;
   logic       in_eom;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic       out_last;
   logic       err;

   // Byte producer / downstream consumer side.
   modport master (
      output in_valid, in_data, in_sel, in_eof, in_eom, out_ready,
      input  in_ready, out_valid, out_data, out_last, err
   );

   // Encoder side.
   modport slave (
      input  in_valid, in_data, in_sel, in_eof, in_eom, out_ready,
      output in_ready, out_valid, out_data, out_last, err
   );
endinterface

// File: rtl/fix_encoder.sv
// fix_encoder: FIX serializer. Turns tag/value character runs into
// "tag=value<SOH>" on the wire, inserting '=' and SOH itself.
// Optional feature macro: FIX_ENCODER_CHECKSUM_EN appends the trailer
// "10=NNN<SOH>" carrying the modulo-256 sum of all message bytes.
// dbg_state exposes the FSM state for checkers.
module fix_encoder #(
   parameter logic [7:0] SOH_C = 8'h01,
   parameter logic [7:0] SEP_C = 8'h3D
) (
   input  logic          clk,
   input  logic          rst,
   fix_encoder_if.slave  bus,
   output logic [3:0]    dbg_state
);

   typedef enum logic [3:0] {
      TAG,
      SEP,
      VALUE,
      TERM
`ifdef FIX_ENCODER_CHECKSUM_EN
      ,
      CK_1,
      CK_0,
      CK_EQ,
      CK_D2,
      CK_D1,
      CK_D0,
      CK_SOH
`endif
   } state_t;

   state_t     state;
   logic       seen_tag;
   logic       eom_q;
   logic       out_valid_q;
   logic [7:0] out_data_q;
   logic       out_last_q;
   logic       err_q;
   logic       slot_free;
   logic       data_bad;

`ifdef FIX_ENCODER_CHECKSUM_EN
   logic [7:0] sum_q;
   logic [7:0] ck_d2;
   logic [7:0] ck_d1;
   logic [7:0] ck_d0;

   // Decimal digits of the running sum for the trailer.
   assign ck_d2 = sum_q / 8'd100;
   assign ck_d1 = (sum_q / 8'd10) % 8'd10;
   assign ck_d0 = sum_q % 8'd10;
`endif

   assign slot_free = !out_valid_q || bus.out_ready;
   assign data_bad  = (bus.in_data == SOH_C) || ((bus.in_data == SEP_C) && !bus.in_sel);

   // A value byte arriving in TAG after the tag run is only peeked (it ends
   // the tag and triggers '='), so ready is withheld for it; it is accepted
   // later in VALUE.
   assign bus.in_ready = !rst && slot_free &&
                         ((state == VALUE) || ((state == TAG) && !(bus.in_sel && seen_tag)));

   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_last  = out_last_q;
   assign bus.err       = err_q;
   assign dbg_state     = state;

   // Serializer FSM with the single registered output slot.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= TAG;
         seen_tag    <= 1'b0;
         eom_q       <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= 8'h00;
         out_last_q  <= 1'b0;
         err_q       <= 1'b0;
`ifdef FIX_ENCODER_CHECKSUM_EN
         sum_q       <= 8'h00;
`endif
      end else begin
         err_q <= 1'b0;
         if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
         end
         if (slot_free) begin
            case (state)
               TAG: begin
                  if (bus.in_valid) begin
                     if (!bus.in_sel) begin
                        out_data_q  <= bus.in_data;
                        out_valid_q <= 1'b1;
                        seen_tag    <= 1'b1;
                        err_q       <= data_bad;
`ifdef FIX_ENCODER_CHECKSUM_EN
                        sum_q       <= sum_q + bus.in_data;
`endif
                     end else if (seen_tag) begin
                        state <= SEP;
                     end else begin
                        err_q <= 1'b1;
                     end
                  end
               end
               SEP: begin
                  out_data_q  <= SEP_C;
                  out_valid_q <= 1'b1;
                  state       <= VALUE;
`ifdef FIX_ENCODER_CHECKSUM_EN
                  sum_q       <= sum_q + SEP_C;
`endif
               end
               VALUE: begin
                  if (bus.in_valid) begin
                     if (bus.in_sel) begin
                        out_data_q  <= bus.in_data;
                        out_valid_q <= 1'b1;
                        err_q       <= data_bad;
`ifdef FIX_ENCODER_CHECKSUM_EN
                        sum_q       <= sum_q + bus.in_data;
`endif
                        if (bus.in_eof) begin
                           eom_q <= bus.in_eom;
                           state <= TERM;
                        end
                     end else begin
                        err_q <= 1'b1;
                     end
                  end
               end
               TERM: begin
                  out_data_q  <= SOH_C;
                  out_valid_q <= 1'b1;
                  seen_tag    <= 1'b0;
                  state       <= TAG;
`ifdef FIX_ENCODER_CHECKSUM_EN
                  sum_q       <= sum_q + SOH_C;
                  if (eom_q) state <= CK_1;
`else
                  out_last_q  <= eom_q;
`endif
               end
`ifdef FIX_ENCODER_CHECKSUM_EN
               CK_1: begin
                  out_data_q  <= 8'h31;
                  out_valid_q <= 1'b1;
                  state       <= CK_0;
               end
               CK_0: begin
                  out_data_q  <= 8'h30;
                  out_valid_q <= 1'b1;
                  state       <= CK_EQ;
               end
               CK_EQ: begin
                  out_data_q  <= SEP_C;
                  out_valid_q <= 1'b1;
                  state       <= CK_D2;
               end
               CK_D2: begin
                  out_data_q  <= 8'h30 + ck_d2;
                  out_valid_q <= 1'b1;
                  state       <= CK_D1;
               end
               CK_D1: begin
                  out_data_q  <= 8'h30 + ck_d1;
                  out_valid_q <= 1'b1;
                  state       <= CK_D0;
               end
               CK_D0: begin
                  out_data_q  <= 8'h30 + ck_d0;
                  out_valid_q <= 1'b1;
                  state       <= CK_SOH;
               end
               CK_SOH: begin
                  out_data_q  <= SOH_C;
                  out_valid_q <= 1'b1;
                  out_last_q  <= 1'b1;
                  sum_q       <= 8'h00;
                  state       <= TAG;
               end
`endif
               default: state <= TAG;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_fix_encoder.sv
// tb_fix_encoder: directed bench for fix_encoder. Expected wire bytes come
// from a message-level model (tag, '=', value, SOH, optional trailer).
module tb_fix_encoder;

   localparam logic [7:0] SOH = 8'h01;
   localparam logic [7:0] SEP = 8'h3D;

   logic       clk;
   logic       rst;
   logic [3:0] dbg_state;

   fix_encoder_if bus ();

   fix_encoder dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus.slave),
      .dbg_state (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- scoreboard state ----------------
   logic [8:0] exp_q[$];   // {last, data}
   logic [8:0] cap_q[$];   // everything the DUT emitted, for literal pins
   int total;
   int bad;
   int err_seen;
   int err_exp;
   int msg_sum;
   int last_sum;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // Compare process: every byte leaving the DUT is checked against the model.
   always @(negedge clk) begin
      if (!rst && bus.out_valid && bus.out_ready) begin
         cap_q.push_back({bus.out_last, bus.out_data});
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL out_byte: got %h want none", {bus.out_last, bus.out_data});
         end else begin
            logic [8:0] e;
            e = exp_q.pop_front();
            if ({bus.out_last, bus.out_data} !== e) begin
               bad++;
               $display("FAIL out_byte: got %h want %h", {bus.out_last, bus.out_data}, e);
            end
         end
      end
      if (bus.err === 1'b1) err_seen++;
   end

   // ---------------- model ----------------
   task automatic model_byte(input logic [7:0] b, input bit last);
      exp_q.push_back({last, b});
      msg_sum = (msg_sum + b) % 256;
   endtask

   task automatic model_field(input logic [31:0] tag, input int tlen,
                              input logic [63:0] val, input int vlen, input bit eom);
      for (int i = 0; i < tlen; i++) model_byte(tag[8*(tlen-1-i) +: 8], 1'b0);
      model_byte(SEP, 1'b0);
      for (int i = 0; i < vlen; i++) model_byte(val[8*(vlen-1-i) +: 8], 1'b0);
`ifdef FIX_ENCODER_CHECKSUM_EN
      model_byte(SOH, 1'b0);
      if (eom) begin
         last_sum = msg_sum;
         exp_q.push_back({1'b0, 8'h31});
         exp_q.push_back({1'b0, 8'h30});
         exp_q.push_back({1'b0, SEP});
         exp_q.push_back({1'b0, 8'(8'h30 + last_sum / 100)});
         exp_q.push_back({1'b0, 8'(8'h30 + (last_sum / 10) % 10)});
         exp_q.push_back({1'b0, 8'(8'h30 + last_sum % 10)});
         exp_q.push_back({1'b1, SOH});
         msg_sum = 0;
      end
`else
      model_byte(SOH, eom);
      if (eom) begin
         last_sum = msg_sum;
         msg_sum  = 0;
      end
`endif
   endtask

   // ---------------- drivers ----------------
   task automatic send_byte(input logic [7:0] d, input bit sel, input bit eof,
                            input bit eom, input bit exp_err);
      bit got;
      int n;
      got = 1'b0;
      n = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.in_sel   = sel;
      bus.in_eof   = eof;
      bus.in_eom   = eom;
      while (!got && n < 200) begin
         @(negedge clk);
         if (bus.in_ready) got = 1'b1;
         @(posedge clk);
         #1;
         n++;
      end
      bus.in_valid = 1'b0;
      if (!got) begin
         total++;
         bad++;
         $display("FAIL accept_timeout: got no in_ready want in_ready for byte %h", d);
      end else if (exp_err) begin
         chk("err_pulse", 32'(bus.err), 32'd1);
         err_exp++;
      end
   endtask

   task automatic send_field(input logic [31:0] tag, input int tlen,
                             input logic [63:0] val, input int vlen, input bit eom);
      logic [7:0] b;
      model_field(tag, tlen, val, vlen, eom);
      for (int i = 0; i < tlen; i++) begin
         b = tag[8*(tlen-1-i) +: 8];
         send_byte(b, 1'b0, 1'b0, 1'b0, (b == SOH) || (b == SEP));
      end
      for (int i = 0; i < vlen; i++) begin
         b = val[8*(vlen-1-i) +: 8];
         send_byte(b, 1'b1, i == vlen - 1, eom && (i == vlen - 1), b == SOH);
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 500) begin
         @(posedge clk);
         n++;
      end
      #1;
      chk("drain", 32'(exp_q.size()), 32'd0);
   endtask

   // Literal wire image of message 35=D, independent of the model.
   task automatic check_pin_35d(input string name);
      logic [8:0] pin[$];
      pin.push_back({1'b0, 8'h33});
      pin.push_back({1'b0, 8'h35});
      pin.push_back({1'b0, 8'h3D});
      pin.push_back({1'b0, 8'h44});
`ifdef FIX_ENCODER_CHECKSUM_EN
      pin.push_back({1'b0, 8'h01});
      pin.push_back({1'b0, 8'h31});
      pin.push_back({1'b0, 8'h30});
      pin.push_back({1'b0, 8'h3D});
      pin.push_back({1'b0, 8'h32});
      pin.push_back({1'b0, 8'h33});
      pin.push_back({1'b0, 8'h34});
      pin.push_back({1'b1, 8'h01});
`else
      pin.push_back({1'b1, 8'h01});
`endif
      chk({name, "_len"}, 32'(cap_q.size()), 32'(pin.size()));
      for (int i = 0; i < pin.size() && i < cap_q.size(); i++)
         chk(name, 32'(cap_q[i]), 32'(pin[i]));
   endtask

   // ---------------- main sequence ----------------
   initial begin
      total = 0; bad = 0; err_seen = 0; err_exp = 0; msg_sum = 0; last_sum = 0;
      rst = 1'b1;
      bus.in_valid = 1'b0; bus.in_data = 8'h00; bus.in_sel = 1'b0;
      bus.in_eof = 1'b0; bus.in_eom = 1'b0; bus.out_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_out_data",  32'(bus.out_data),  32'h00);
      chk("rst_out_last",  32'(bus.out_last),  32'd0);
      chk("rst_err",       32'(bus.err),       32'd0);
      chk("rst_in_ready",  32'(bus.in_ready),  32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // 35=D, end of message
      cap_q.delete();
      send_field("35", 2, "D", 1, 1'b1);
      drain();
      chk("model_sum_35d", 32'(last_sum), 32'd234);
      check_pin_35d("pin_35d");

      // two fields, checksum spans both
      send_field("8", 1, "A", 1, 1'b0);
      send_field("9", 1, "B", 1, 1'b1);
      drain();

      // 1=0x98: checksum 7 -> digits 0,0,7
      cap_q.delete();
      send_field("1", 1, 64'h98, 1, 1'b1);
      drain();
      chk("model_sum_198", 32'(last_sum), 32'd7);
`ifdef FIX_ENCODER_CHECKSUM_EN
      chk("pin_198_len", 32'(cap_q.size()), 32'd11);
      if (cap_q.size() == 11) begin
         chk("pin_198_d2", 32'(cap_q[7]), 32'h030);
         chk("pin_198_d1", 32'(cap_q[8]), 32'h030);
         chk("pin_198_d0", 32'(cap_q[9]), 32'h037);
      end
`endif

      // backpressure mid-value
      fork
         send_field("55", 2, "ABCDEF", 6, 1'b1);
         begin
            logic [7:0] held;
            repeat (6) @(posedge clk);
            #1;
            bus.out_ready = 1'b0;
            @(posedge clk);
            #1;
            held = bus.out_data;
            chk("bp_valid", 32'(bus.out_valid), 32'd1);
            repeat (4) begin
               @(posedge clk);
               #1;
               chk("bp_hold", 32'(bus.out_data), 32'(held));
               chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
            end
            bus.out_ready = 1'b1;
         end
      join
      drain();

      // value byte before any tag: dropped, one-cycle err
      send_byte("X", 1'b1, 1'b0, 1'b0, 1'b1);
      @(posedge clk);
      #1;
      chk("err_one_cycle", 32'(bus.err), 32'd0);
      send_field("11", 2, "Z", 1, 1'b1);
      drain();

      // SOH inside a value: forwarded, err flagged
      send_field("58", 2, {8'h41, 8'h01, 8'h42}, 3, 1'b1);
      drain();

      // reset after "35=" has been emitted
      exp_q.push_back({1'b0, 8'h33});
      exp_q.push_back({1'b0, 8'h35});
      exp_q.push_back({1'b0, SEP});
      send_byte("3", 1'b0, 1'b0, 1'b0, 1'b0);
      send_byte("5", 1'b0, 1'b0, 1'b0, 1'b0);
      bus.in_valid = 1'b1; bus.in_data = "D"; bus.in_sel = 1'b1;
      bus.in_eof = 1'b1; bus.in_eom = 1'b1;
      begin
         int n;
         bit hit;
         n = 0;
         hit = 1'b0;
         while (!hit && n < 50) begin
            @(negedge clk);
            if (bus.out_valid && bus.out_data == SEP) begin
               hit = 1'b1;
               rst = 1'b1;
               bus.in_valid = 1'b0;
            end else begin
               n++;
            end
         end
         chk("rst_sep_seen", 32'(hit), 32'd1);
         rst = 1'b1;
         bus.in_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      chk("rst_mid_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_mid_in_ready", 32'(bus.in_ready), 32'd0);
      rst = 1'b0;
      msg_sum = 0;
      exp_q.delete();
      @(posedge clk);
      #1;
      cap_q.delete();
      send_field("35", 2, "D", 1, 1'b1);
      drain();
      chk("model_sum_after_rst", 32'(last_sum), 32'd234);
      check_pin_35d("pin_after_rst");

      repeat (3) @(posedge clk);
      #1;
      chk("err_count", 32'(err_seen), 32'(err_exp));
      chk("exp_empty", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fix_encoder.md
# fix_encoder

FIX message serializer, the transmit-side counterpart of the FIX field parser. Accepts a byte stream of tag and value characters with field/message framing sideband, and emits the wire byte stream `tag=value<SOH>` per field, inserting the `=` separator and SOH terminator itself. Optionally appends the FIX trailer field `10=NNN<SOH>` with the modulo-256 checksum. Sits between the order-formatting logic and the outbound byte transport.

## Interface

- Parameters:
- SOH_C, 8'h01, field terminator byte
- SEP_C, 8'h3D, tag/value separator byte (`=`)
- Ports:
- clk  input  1  single clock; all logic on rising edge
- rst  input  1  reset, synchronous, active-high
- in_valid  input  1  input byte valid
- in_ready  output  1  input byte accepted when in_valid && in_ready
- in_data  input  8  tag or value character
- in_sel  input  1  0 = tag byte, 1 = value byte
- in_eof  input  1  last value byte of field (honoured only with in_sel=1)
- in_eom  input  1  last field of message (honoured only with in_eof=1)
- out_valid  output  1  output byte valid
- out_ready  input  1  downstream accepts when out_valid && out_ready
- out_data  output  8  wire byte
- out_last  output  1  marks final byte of message
- err  output  1  one-cycle protocol-error pulse

## Operation

- States: TAG, SEP, VALUE, TERM, then (checksum only) CK_1, CK_0, CK_EQ, CK_D2, CK_D1, CK_D0, CK_SOH. Reset state TAG; `seen_tag` flag cleared.
- Single output register (out_data/out_valid/out_last). "Slot free" = !out_valid || out_ready. A byte is loaded only when slot free.
- TAG: tag byte (in_sel=0) consumed and forwarded, seen_tag=1. Value byte (in_sel=1) with seen_tag=1: not consumed; go to SEP. Value byte with seen_tag=0: consumed, dropped, err pulse, stay TAG.
- SEP: emit SEP_C (no input consumed), go to VALUE.
- VALUE: value byte consumed and forwarded; if in_eof go to TERM. Tag byte in VALUE: consumed, dropped, err pulse.
- TERM: emit SOH_C, seen_tag=0; latched eom ? (checksum state CK_1, or TAG with out_last=1) : TAG.
- Data check: in_data==SOH_C in any state, or in_data==SEP_C with in_sel=0: byte still forwarded, err pulses.
- in_ready = !rst && slot free && state in {TAG, VALUE}.
- Checksum: 8-bit accumulator adds every emitted byte of the message (tags, values, `=`, SOH), wraps mod 256. Trailer bytes are not accumulated. Digits: d2 = sum/100, d1 = (sum/10)%10, d0 = sum%10, each emitted as 8'h30+digit, always three digits (leading zeros). Sequence `1`,`0`,`=`,d2,d1,d0,SOH_C; out_last=1 on that final SOH. Accumulator cleared when final SOH is loaded.

## Timing

- Reset values: out_valid=0, out_data=8'h00, out_last=0, err=0, in_ready=0 while rst high; accumulator=0, state TAG.
- Latency: accepted byte appears on out_data the following cycle.
- Throughput: 1 byte/cycle within tag and within value runs; SEP and TERM each insert one input bubble; trailer adds 7 cycles.
- Backpressure: while out_valid && !out_ready, out_data/out_last hold stable, FSM stalls, in_ready=0.
- err is registered, asserts the cycle after the offending acceptance.
- Reset mid-message: next cycle out_valid=0, partial message discarded, checksum cleared; no trailer emitted.

## Configuration

- FIX_ENCODER_CHECKSUM_EN defined: accumulator and CK_* states present; out_last on trailer SOH.
- Undefined: no accumulator, no CK_* states; out_last on the TERM SOH of the in_eom field; TERM returns directly to TAG.

## Test plan

- Fields "35"/"D" (eom), out_ready=1 -> `3`,`5`,`=`,`D`,8'h01,`1`,`0`,`=`,`2`,`3`,`4`,8'h01; out_last only on final byte (sum 0xEA=234). Without macro: five bytes, out_last on 8'h01.
- Two fields "8"/"A", "9"/"B"(eom) -> `8=A`,SOH,`9=B`,SOH then trailer; accumulator spans both fields.
- Field "1"/8'h98 (eom) -> checksum 7, trailer digits `0`,`0`,`7`.
- out_ready low 5 cycles mid-value -> out_data constant, in_ready=0, no byte lost or duplicated.
- Value byte as first byte of field -> byte dropped, err=1 one cycle; SOH inside value -> forwarded, err=1.
- rst asserted after "35=" emitted -> out_valid=0 next cycle; following message "35"/"D" yields trailer `234` again.
